i2c_slave_responder: RTL and testbench
======================================

I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h22, 7-bit I2C address the block answers to.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, byte width on the data ports.
REQ-003 SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have scl_i  input  1  raw I2C clock from the bus.
REQ-006 SHALL have sda_i  input  1  raw I2C data from the bus.
REQ-007 SHALL have scl_oe  output  1  1 = pull SCL low (open-drain), used only for clock stretching.
REQ-008 SHALL have sda_oe  output  1  1 = pull SDA low (open-drain).
REQ-009 SHALL have wr_valid  output  1  one-cycle pulse: wr_data holds a received byte.
REQ-010 SHALL have wr_data  output  DATA_WIDTH  last byte written by the master.
REQ-011 SHALL have rd_ready  output  1  block requests the next read byte.
REQ-012 SHALL have rd_valid  input  1  rd_data valid; transfer occurs when rd_valid and rd_ready are both 1.
REQ-013 SHALL have rd_data  input  DATA_WIDTH  byte to return to the master.
REQ-014 SHALL have start_det, stop_det  output  1  one-cycle pulses on START/repeated START and STOP.
REQ-015 SHALL have busy  output  1  high from an address match until STOP or NACK.
REQ-016 SHALL have op  output  1  R/W bit of the current matched transfer (1 = read).

Function
REQ-017 SHALL pass scl_i/sda_i through 2-FF synchronizers and detect edges from the registered copies, giving 3 clk of input latency.
REQ-018 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high, in any state.
REQ-019 SHALL use FSM states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP.
REQ-020 SHALL go to ADDR on START from any state; on STOP from any state, go to IDLE and release both outputs.
REQ-021 SHALL sample SDA MSB-first on SCL rising edges in ADDR and WR_DATA.
REQ-022 SHALL go to ADDR_ACK after 8 address bits only if addr[7:1]==SLAVE_ADDR; otherwise go to WAIT_STOP with no ACK and no pulses.
REQ-023 SHALL drive the ACK (sda_oe=1) from the SCL falling edge after bit 8 to the SCL falling edge after bit 9.
REQ-024 SHALL, on a write, pulse wr_valid on the SCL falling edge that starts WR_ACK, and ACK every data byte.
REQ-025 SHALL, on a read, enter RD_LOAD after the address ACK, and also after each master ACK.
REQ-026 SHALL, in RD_LOAD, hold rd_ready=1 until handshake, load the shift register, then enter RD_DATA.
REQ-027 SHALL, in RD_DATA, change sda_oe only on SCL falling edges, as sda_oe = ~bit, MSB-first.
REQ-028 SHALL release SDA and sample the master's ACK on the 9th SCL rising edge; ACK -> RD_LOAD, NACK -> WAIT_STOP.
REQ-029 SHALL have no byte-count limit, and SHALL allow a repeated START between write and read phases with no STOP.

Reset
REQ-030 SHALL, while rst=0, put the FSM in IDLE, hold scl_oe, sda_oe, wr_valid, rd_ready, start_det, stop_det, busy and op at 0 and wr_data at 0, and preset synchronizers to 1.
REQ-031 SHALL, when reset releases mid-transfer, ignore bus activity until the next START.

Configuration
REQ-032 SHALL, with I2C_RESP_STRETCH_EN defined, hold scl_oe=1 in RD_LOAD after SCL falls until the rd handshake, then release SCL.
REQ-033 SHALL, without I2C_RESP_STRETCH_EN, sample rd_data at the RD_LOAD SCL falling edge; if rd_valid=0, send 8'hFF, and scl_oe stays 0 permanently.

Structure
REQ-034 SHALL take the state enum and START/STOP/ACK constants from package i2c_resp_pkg.
REQ-035 SHALL implement the synchronizer and edge detector as sub-module i2c_resp_sync, instantiated once each for SCL and SDA.

Verification
REQ-036 SHALL cover: write to address byte 0x44, data 0x00..0x1F -> 32 wr_valid pulses with data 0..31, ACK on all 33 bytes, op=0.
REQ-037 SHALL cover: read at 0x45 with rd_data 100..131, master NACK on the 32nd byte -> bus bytes 100..131, then WAIT_STOP with SDA released.
REQ-038 SHALL cover: address byte 0x46 (0x23) -> no ACK (SDA high on 9th clock), no wr_valid, busy=0.
REQ-039 SHALL cover: write 0x40, repeated START, read 0x45 returning 0x3F -> start_det pulses twice, op goes 0 to 1, one stop_det.
REQ-040 SHALL cover: I2C_RESP_STRETCH_EN, rd_valid delayed 50 clk -> SCL held low for at least 50 clk, then byte correct.
REQ-041 SHALL cover: rst asserted mid-byte of a write -> outputs 0 at once, no wr_valid, next START/0x44 ACKed normally.

Source files
------------

// File: rtl/i2c_resp_pkg.sv
// Shared constants for the I2C slave responder: FSM state codes, byte/ACK
// encodings and the SDA levels that identify START and STOP.
package i2c_resp_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned ADDR_BITS = 7;
    localparam int unsigned BITCNT_W  = 4;

    localparam logic [STATE_W-1:0] ST_IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] ST_ADDR      = 4'd1;
    localparam logic [STATE_W-1:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [STATE_W-1:0] ST_WR_DATA   = 4'd3;
    localparam logic [STATE_W-1:0] ST_WR_ACK    = 4'd4;
    localparam logic [STATE_W-1:0] ST_RD_LOAD   = 4'd5;
    localparam logic [STATE_W-1:0] ST_RD_DATA   = 4'd6;
    localparam logic [STATE_W-1:0] ST_RD_ACK    = 4'd7;
    localparam logic [STATE_W-1:0] ST_WAIT_STOP = 4'd8;

    // SDA level during the 9th clock: low acknowledges, high refuses
    localparam logic SDA_ACK  = 1'b0;
    localparam logic SDA_NACK = 1'b1;

    // SDA level reached by the edge that marks START / STOP while SCL is high
    localparam logic START_SDA_LVL = 1'b0;
    localparam logic STOP_SDA_LVL  = 1'b1;

endpackage

// File: rtl/i2c_resp_sync.sv
// Two-flop synchronizer plus registered edge detector for one raw bus line.
// level/rise/fall all appear 3 clk after the pin changes; flops preset to 1
// (idle bus level) in reset.
module i2c_resp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;
    logic       level_q;
    logic       rise_q;
    logic       fall_q;

    // Synchronize, keep one older copy, register level and edges together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], d_i};
            level_q <= sync_q[1];
            rise_q  <= sync_q[1] & ~sync_q[2];
            fall_q  <= ~sync_q[1] & sync_q[2];
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave responder: matches a 7-bit address, ACKs and delivers written
// bytes, fetches read bytes through a valid/ready handshake.
// Optional macro I2C_RESP_STRETCH_EN: stretch SCL in RD_LOAD until read data
// is handed over; without it an unready source returns 8'hFF.
module i2c_slave_responder
    import i2c_resp_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h22,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_oe,
    output logic                  sda_oe,
    output logic                  wr_valid,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_ready,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  busy,
    output logic                  op
);

`ifdef I2C_RESP_STRETCH_EN
    localparam logic STRETCH_EN = 1'b1;
`else
    localparam logic STRETCH_EN = 1'b0;
`endif

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_c, stop_c;
    logic rd_take_c;
    logic [BYTE_BITS-1:0] load_byte_c;

    logic [STATE_W-1:0]    state_q, state_d;
    logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_BITS-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
    logic wr_valid_q, wr_valid_d, rd_ready_q, rd_ready_d;
    logic start_q, start_d, stop_q, stop_d;
    logic busy_q, busy_d, op_q, op_d;

    i2c_resp_sync u_scl_sync (
        .clk(clk), .rst(rst), .d_i(scl_i),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_resp_sync u_sda_sync (
        .clk(clk), .rst(rst), .d_i(sda_i),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    // Bus conditions: SDA edge while SCL is high
    assign start_c = scl_lvl & (sda_rise | sda_fall) & (sda_lvl == START_SDA_LVL);
    assign stop_c  = scl_lvl & (sda_rise | sda_fall) & (sda_lvl == STOP_SDA_LVL);

`ifdef I2C_RESP_STRETCH_EN
    assign rd_take_c   = rd_ready_q & rd_valid;
    assign load_byte_c = BYTE_BITS'(rd_data);
`else
    assign rd_take_c   = rd_ready_q;
    assign load_byte_c = rd_valid ? BYTE_BITS'(rd_data) : '1;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wr_data_q  <= '0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_ready_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            op_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wr_data_q  <= wr_data_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            rd_ready_q <= rd_ready_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            op_q       <= op_d;
        end
    end

    // Next-state and output decode; START/STOP override every state
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wr_data_d  = wr_data_q;
        scl_oe_d   = 1'b0;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        rd_ready_d = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        busy_d     = busy_q;
        op_d       = op_q;

        if (stop_c) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            stop_d    = 1'b1;
        end else if (start_c) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            start_d   = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[BYTE_BITS-2:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                        if (bit_cnt_q == BITCNT_W'(BYTE_BITS - 1)) begin
                            if (shift_q[ADDR_BITS-1:0] == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                op_d    = sda_lvl;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // first fall starts the ACK, second fall ends it
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~SDA_ACK;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = op_q ? ST_RD_LOAD : ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise && (bit_cnt_q < BITCNT_W'(BYTE_BITS))) begin
                        shift_d   = {shift_q[BYTE_BITS-2:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                    end else if (scl_fall && (bit_cnt_q == BITCNT_W'(BYTE_BITS))) begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = DATA_WIDTH'(shift_q);
                        sda_oe_d   = ~SDA_ACK;
                        state_d    = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_WR_DATA;
                    end
                end
                ST_RD_LOAD: begin
                    // only fetch once SCL is low so the first bit can be driven
                    if (!scl_lvl) begin
                        scl_oe_d = STRETCH_EN;
                        if (rd_take_c) begin
                            shift_d   = load_byte_c;
                            sda_oe_d  = ~load_byte_c[BYTE_BITS-1];
                            bit_cnt_d = '0;
                            state_d   = ST_RD_DATA;
                        end else begin
                            rd_ready_d = 1'b1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == BITCNT_W'(BYTE_BITS - 1)) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            shift_d   = {shift_q[BYTE_BITS-2:0], 1'b0};
                            sda_oe_d  = ~shift_q[BYTE_BITS-2];
                            bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == SDA_ACK) begin
                            state_d = ST_RD_LOAD;
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign wr_valid  = wr_valid_q;
    assign wr_data   = wr_data_q;
    assign rd_ready  = rd_ready_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign busy      = busy_q;
    assign op        = op_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bus-level I2C master with open-drain bus
// model, a read-data source and a transaction-level expectation model.
module tb_i2c_slave_responder;

    localparam logic [6:0] SLV = 7'h22;
    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic scl_bus, sda_bus;

    logic scl_oe, sda_oe, wr_valid, rd_ready, rd_valid;
    logic start_det, stop_det, busy, op;
    logic [7:0] wr_data, rd_data;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_stop = 0;
    int oe_run = 0;
    int max_oe_run = 0;
    int rd_delay = 0;
    int rd_wait = 0;
    logic [7:0] wr_seen[$];
    logic [7:0] rd_src[$];

    assign scl_bus = scl_m & ~scl_oe;
    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_responder #(.SLAVE_ADDR(SLV), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_data(wr_data),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .start_det(start_det), .stop_det(stop_det), .busy(busy), .op(op)
    );

    always #5 clk = ~clk;

    // Monitor: collect written bytes, count pulses, track longest SCL hold
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (wr_valid) wr_seen.push_back(wr_data);
                if (start_det) n_start++;
                if (stop_det) n_stop++;
            end
            if (scl_oe) oe_run++;
            else oe_run = 0;
            if (oe_run > max_oe_run) max_oe_run = oe_run;
        end
    end

    // Read-data source: presents queue head after rd_delay cycles of rd_ready
    initial begin
        rd_valid = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                @(posedge clk);
                #1;
                void'(rd_src.pop_front());
                rd_wait = 0;
            end else if (rd_ready) begin
                rd_wait++;
            end
            if (rd_src.size() > 0 && rd_wait >= rd_delay) begin
                rd_valid = 1'b1;
                rd_data  = rd_src[0];
            end else begin
                rd_valid = 1'b0;
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // ---------------- bus-level master ----------------
    task automatic qwait();
        repeat (Q) @(posedge clk);
    endtask

    task automatic scl_up();
        int t;
        scl_m = 1'b1;
        t = 0;
        #1;
        while (scl_bus !== 1'b1 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 5000) begin
            n_cmp++;
            n_err++;
            $display("FAIL scl_release: SCL still low after %0d clk, required release", t);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait(); scl_up(); qwait();
        sda_m = 1'b0; qwait(); scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait(); scl_up(); qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; qwait(); scl_up(); qwait(); qwait(); scl_m = 1'b0; qwait();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; qwait(); scl_up(); qwait(); b = sda_bus; qwait(); scl_m = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ackn);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        recv_bit(ackn);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) recv_bit(v[i]);
        send_bit(nack);
    endtask

    // Expected behaviour at transaction level
    function automatic logic addr_hit(input logic [7:0] a);
        return (a[7:1] == SLV);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({scl_oe, sda_oe, wr_valid, rd_ready, start_det, stop_det, busy, op} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {scl_oe, sda_oe, wr_valid, rd_ready, start_det, stop_det, busy, op});
        end
        n_cmp++;
        if (wr_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_wr_data: got %h required 00", wr_data);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_write_seq();
        logic ackn;
        logic [7:0] exp[$];
        wr_seen.delete();
        bus_start();
        send_byte(8'h44, ackn);
        n_cmp++;
        if (ackn !== 1'b0) begin n_err++; $display("FAIL wseq_addr_ack: got %b required 0", ackn); end
        n_cmp++;
        if ({busy, op} !== 2'b10) begin n_err++; $display("FAIL wseq_busy_op: got %b required 10", {busy, op}); end
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i), ackn);
            exp.push_back(8'(i));
            n_cmp++;
            if (ackn !== 1'b0) begin n_err++; $display("FAIL wseq_data_ack[%0d]: got %b required 0", i, ackn); end
        end
        bus_stop();
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (wr_seen.size() != exp.size()) begin
            n_err++; $display("FAIL wseq_count: got %0d required %0d", wr_seen.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < wr_seen.size(); i++) begin
            n_cmp++;
            if (wr_seen[i] !== exp[i]) begin
                n_err++; $display("FAIL wseq_data[%0d]: got %h required %h", i, wr_seen[i], exp[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL wseq_busy_after_stop: got %b required 0", busy); end
    endtask

    task automatic test_write_rand();
        for (int it = 0; it < 4; it++) begin
            logic [7:0] a, d;
            logic ackn;
            logic exp_ack;
            logic [7:0] exp[$];
            int len;
            wr_seen.delete();
            if (it % 2 == 0) a = {SLV, 1'b0};
            else begin
                a = 8'($urandom_range(0, 255)) & 8'hFE;
                if (a[7:1] == SLV) a = a ^ 8'h02;
            end
            exp_ack = addr_hit(a);
            len = $urandom_range(1, 5);
            bus_start();
            send_byte(a, ackn);
            n_cmp++;
            if (ackn !== ~exp_ack) begin
                n_err++; $display("FAIL wrand_addr_ack[%0d] addr %h: got nack=%b required %b", it, a, ackn, ~exp_ack);
            end
            n_cmp++;
            if (busy !== exp_ack) begin n_err++; $display("FAIL wrand_busy[%0d]: got %b required %b", it, busy, exp_ack); end
            for (int k = 0; k < len; k++) begin
                d = 8'($urandom_range(0, 255));
                send_byte(d, ackn);
                if (exp_ack) exp.push_back(d);
                n_cmp++;
                if (ackn !== ~exp_ack) begin
                    n_err++; $display("FAIL wrand_data_ack[%0d.%0d]: got nack=%b required %b", it, k, ackn, ~exp_ack);
                end
            end
            bus_stop();
            repeat (6) @(posedge clk);
            n_cmp++;
            if (wr_seen.size() != exp.size()) begin
                n_err++; $display("FAIL wrand_count[%0d]: got %0d required %0d", it, wr_seen.size(), exp.size());
            end
            for (int i = 0; i < exp.size() && i < wr_seen.size(); i++) begin
                n_cmp++;
                if (wr_seen[i] !== exp[i]) begin
                    n_err++; $display("FAIL wrand_data[%0d.%0d]: got %h required %h", it, i, wr_seen[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_read_seq();
        logic ackn;
        logic [7:0] v;
        rd_delay = 0;
        rd_wait = 0;
        rd_src.delete();
        for (int i = 0; i < 32; i++) rd_src.push_back(8'(100 + i));
        bus_start();
        send_byte(8'h45, ackn);
        n_cmp++;
        if (ackn !== 1'b0) begin n_err++; $display("FAIL rseq_addr_ack: got %b required 0", ackn); end
        n_cmp++;
        if ({busy, op} !== 2'b11) begin n_err++; $display("FAIL rseq_busy_op: got %b required 11", {busy, op}); end
        for (int i = 0; i < 32; i++) begin
            recv_byte(i == 31, v);
            n_cmp++;
            if (v !== 8'(100 + i)) begin n_err++; $display("FAIL rseq_byte[%0d]: got %0d required %0d", i, v, 100 + i); end
        end
        n_cmp++;
        if ({sda_oe, busy} !== 2'b00) begin
            n_err++; $display("FAIL rseq_after_nack: sda_oe,busy got %b required 00", {sda_oe, busy});
        end
        n_cmp++;
        if (rd_src.size() != 0) begin n_err++; $display("FAIL rseq_consumed: left %0d required 0", rd_src.size()); end
        bus_stop();
    endtask

    task automatic test_read_rand();
        for (int it = 0; it < 3; it++) begin
            logic ackn;
            logic [7:0] v;
            logic [7:0] exp[$];
            int len;
            len = $urandom_range(1, 4);
            rd_src.delete();
            for (int i = 0; i < len; i++) begin
                exp.push_back(8'($urandom_range(0, 255)));
                rd_src.push_back(exp[i]);
            end
            bus_start();
            send_byte({SLV, 1'b1}, ackn);
            n_cmp++;
            if (ackn !== 1'b0) begin n_err++; $display("FAIL rrand_addr_ack[%0d]: got %b required 0", it, ackn); end
            for (int i = 0; i < len; i++) begin
                recv_byte(i == len - 1, v);
                n_cmp++;
                if (v !== exp[i]) begin n_err++; $display("FAIL rrand_byte[%0d.%0d]: got %h required %h", it, i, v, exp[i]); end
            end
            bus_stop();
        end
    endtask

    task automatic test_nomatch();
        logic ackn;
        wr_seen.delete();
        bus_start();
        send_byte(8'h46, ackn);
        n_cmp++;
        if (ackn !== 1'b1) begin n_err++; $display("FAIL nomatch_addr: sda got %b required 1", ackn); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL nomatch_busy: got %b required 0", busy); end
        send_byte(8'h5A, ackn);
        n_cmp++;
        if (ackn !== 1'b1) begin n_err++; $display("FAIL nomatch_data: sda got %b required 1", ackn); end
        bus_stop();
        repeat (6) @(posedge clk);
        n_cmp++;
        if (wr_seen.size() != 0) begin n_err++; $display("FAIL nomatch_wr_valid: got %0d pulses required 0", wr_seen.size()); end
    endtask

    task automatic test_repeated_start();
        logic ackn;
        logic [7:0] v;
        int s0, p0;
        wr_seen.delete();
        rd_src.delete();
        rd_src.push_back(8'h3F);
        repeat (4) @(posedge clk);
        s0 = n_start;
        p0 = n_stop;
        bus_start();
        send_byte(8'h44, ackn);
        send_byte(8'h40, ackn);
        n_cmp++;
        if ({ackn, op} !== 2'b00) begin n_err++; $display("FAIL rstart_wr: ack,op got %b required 00", {ackn, op}); end
        bus_start();
        send_byte(8'h45, ackn);
        n_cmp++;
        if ({ackn, op} !== 2'b01) begin n_err++; $display("FAIL rstart_rd: ack,op got %b required 01", {ackn, op}); end
        recv_byte(1'b1, v);
        n_cmp++;
        if (v !== 8'h3F) begin n_err++; $display("FAIL rstart_byte: got %h required 3f", v); end
        bus_stop();
        repeat (6) @(posedge clk);
        n_cmp++;
        if ((n_start - s0) != 2 || (n_stop - p0) != 1) begin
            n_err++; $display("FAIL rstart_pulses: start %0d stop %0d required 2 1", n_start - s0, n_stop - p0);
        end
        n_cmp++;
        if (wr_seen.size() != 1 || wr_seen[0] !== 8'h40) begin
            n_err++; $display("FAIL rstart_wr_data: got %0d bytes required one 40", wr_seen.size());
        end
    endtask

`ifdef I2C_RESP_STRETCH_EN
    task automatic test_stretch();
        logic ackn;
        logic [7:0] v, e0, e1;
        e0 = 8'($urandom_range(0, 255));
        e1 = 8'($urandom_range(0, 255));
        rd_src.delete();
        rd_src.push_back(e0);
        rd_src.push_back(e1);
        rd_delay = 50;
        rd_wait = 0;
        max_oe_run = 0;
        bus_start();
        send_byte(8'h45, ackn);
        recv_byte(1'b0, v);
        n_cmp++;
        if (v !== e0) begin n_err++; $display("FAIL stretch_byte0: got %h required %h", v, e0); end
        recv_byte(1'b1, v);
        n_cmp++;
        if (v !== e1) begin n_err++; $display("FAIL stretch_byte1: got %h required %h", v, e1); end
        bus_stop();
        n_cmp++;
        if (max_oe_run < 50) begin n_err++; $display("FAIL stretch_hold: SCL held %0d clk required >=50", max_oe_run); end
        rd_delay = 0;
    endtask
`else
    task automatic test_stretch();
        logic ackn;
        logic [7:0] v;
        rd_src.delete();
        rd_src.push_back(8'h5A);
        rd_delay = 50;
        rd_wait = 0;
        bus_start();
        send_byte(8'h45, ackn);
        recv_byte(1'b0, v);
        n_cmp++;
        if (v !== 8'hFF) begin n_err++; $display("FAIL nodata_byte0: got %h required ff", v); end
        recv_byte(1'b1, v);
        n_cmp++;
        if (v !== 8'hFF) begin n_err++; $display("FAIL nodata_byte1: got %h required ff", v); end
        bus_stop();
        n_cmp++;
        if (max_oe_run != 0) begin n_err++; $display("FAIL nodata_scl_oe: held %0d clk required 0", max_oe_run); end
        rd_src.delete();
        rd_delay = 0;
    endtask
`endif

    task automatic test_reset_mid();
        logic ackn;
        logic [7:0] d;
        wr_seen.delete();
        bus_start();
        send_byte(8'h44, ackn);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({scl_oe, sda_oe, wr_valid, rd_ready, start_det, stop_det, busy, op} !== 8'h00 || wr_data !== 8'h00) begin
            n_err++; $display("FAIL midrst_outputs: got %b/%h required 0",
                              {scl_oe, sda_oe, wr_valid, rd_ready, start_det, stop_det, busy, op}, wr_data);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        recv_bit(ackn);
        n_cmp++;
        if (ackn !== 1'b1) begin n_err++; $display("FAIL midrst_ignored_ack: sda got %b required 1", ackn); end
        bus_stop();
        repeat (6) @(posedge clk);
        n_cmp++;
        if (wr_seen.size() != 0) begin n_err++; $display("FAIL midrst_wr_valid: got %0d required 0", wr_seen.size()); end
        d = 8'($urandom_range(0, 255));
        bus_start();
        send_byte(8'h44, ackn);
        n_cmp++;
        if (ackn !== 1'b0) begin n_err++; $display("FAIL midrst_readdr: got %b required 0", ackn); end
        send_byte(d, ackn);
        bus_stop();
        repeat (6) @(posedge clk);
        n_cmp++;
        if (wr_seen.size() != 1 || wr_seen[0] !== d) begin
            n_err++; $display("FAIL midrst_write: got %0d bytes required one %h", wr_seen.size(), d);
        end
    endtask

    initial begin
        test_reset();
        test_write_seq();
        test_write_rand();
        test_read_seq();
        test_read_rand();
        test_nomatch();
        test_repeated_start();
        test_stretch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
